xif_mem_arbiter: RTL and testbench

//  Shares the single X-interface memory channel between NUM_REQ coprocessor memory clients (wbits reader, future writers).

---
 rtl/custom_instr_pkg.sv | 22 ++
 rtl/arb_route_fifo.sv | 56 +++++
 rtl/xif_mem_arbiter.sv | 169 ++++++++++++++++
 tb/tb_xif_mem_arbiter.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/custom_instr_pkg.sv
// Shared types for the X-interface memory arbiter: FSM states and the latched request record.
// No logic of its own; imported by xif_mem_arbiter.
// Field widths follow the 32-bit X-interface memory channel.
package custom_instr_pkg;

    localparam int unsigned ADDR_W = 32;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned BE_W   = 4;

    typedef enum logic {
        ARB_IDLE  = 1'b0,
        ARB_ISSUE = 1'b1
    } arb_state_e;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic              we;
        logic [BE_W-1:0]   be;
        logic [DATA_W-1:0] wdata;
    } arb_mem_req_t;

endpackage

// File: rtl/arb_route_fifo.sv
// Route FIFO: remembers which client issued each in-flight transaction, oldest at the head.
// Latency: push visible at head next cycle; head is combinational from storage.
// Backpressure: push ignored when full unless a pop happens the same cycle; pop ignored when empty.
module arb_route_fifo #(
    parameter int unsigned DEPTH = 2,
    parameter int unsigned WIDTH = 1
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             push_i,
    input  logic [WIDTH-1:0] push_dat_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] pop_dat_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);
    localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_cnt;
    logic             w_push;
    logic             w_pop;

    assign empty_o   = (r_cnt == '0);
    assign full_o    = (r_cnt == FULL_CNT);
    assign w_pop     = pop_i && !empty_o;
    assign w_push    = push_i && (!full_o || w_pop);
    assign pop_dat_o = r_mem[r_rd_ptr];

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_cnt    <= '0;
            for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
        end else begin
            if (w_push) begin
                r_mem[r_wr_ptr] <= push_dat_i;
                r_wr_ptr        <= (r_wr_ptr == LAST_PTR) ? '0 : r_wr_ptr + 1'b1;
            end
            if (w_pop) r_rd_ptr <= (r_rd_ptr == LAST_PTR) ? '0 : r_rd_ptr + 1'b1;
            unique case ({w_push, w_pop})
                2'b10:   r_cnt <= r_cnt + 1'b1;
                2'b01:   r_cnt <= r_cnt - 1'b1;
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/xif_mem_arbiter.sv
// Round-robin arbiter sharing one X-interface memory channel; in-order responses routed to the issuer.
// Latency: grant same cycle, mem_valid_o next cycle; response forwarded combinationally. XIF_ARB_LOCK_EN adds grant locking.
// Backpressure: holds mem_* until mem_ready_i; no grants while MAX_OUTST transactions are unanswered.
module xif_mem_arbiter
    import custom_instr_pkg::*;
#(
    parameter int unsigned NUM_REQ   = 2,
    parameter int unsigned MAX_OUTST = 2,
    parameter int unsigned ID_WIDTH  = 4
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic [NUM_REQ-1:0]    req_valid_i,
    output logic [NUM_REQ-1:0]    req_ready_o,
    input  logic [NUM_REQ*32-1:0] req_addr_i,
    input  logic [NUM_REQ-1:0]    req_we_i,
    input  logic [NUM_REQ*4-1:0]  req_be_i,
    input  logic [NUM_REQ*32-1:0] req_wdata_i,
    input  logic [NUM_REQ-1:0]    req_lock_i,
    output logic [NUM_REQ-1:0]    resp_valid_o,
    output logic [31:0]           resp_rdata_o,
    output logic                  mem_valid_o,
    input  logic                  mem_ready_i,
    output logic [31:0]           mem_addr_o,
    output logic                  mem_we_o,
    output logic [3:0]            mem_be_o,
    output logic [31:0]           mem_wdata_o,
    output logic [ID_WIDTH-1:0]   mem_id_o,
    input  logic                  mem_result_valid_i,
    input  logic [31:0]           mem_result_rdata_i,
    output logic                  err_o
);

    localparam int unsigned IDX_W = $clog2(NUM_REQ);
    localparam int unsigned CNT_W = $clog2(MAX_OUTST + 1);
    localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_OUTST);

    arb_state_e          r_state;
    arb_mem_req_t        r_req;
    logic [IDX_W-1:0]    r_src;
    logic [CNT_W-1:0]    r_count;
    logic [ID_WIDTH-1:0] r_tag;
    logic [IDX_W-1:0]    r_rr_ptr;
    logic                r_err;

    logic [NUM_REQ-1:0]  w_elig;
    logic                w_found;
    logic [IDX_W-1:0]    w_win;
    int unsigned         w_sel;
    arb_mem_req_t        w_sel_req;
    logic                w_adv;
    logic                w_grant;
    logic                w_hs;
    logic                w_resp;
    logic [IDX_W-1:0]    w_fifo_head;
    logic                w_fifo_empty;
    logic                w_fifo_full_unused;

    function automatic logic [IDX_W-1:0] rr_idx(input logic [IDX_W-1:0] base, input int unsigned off);
        int unsigned s;
        s = 32'(base) + off;
        if (s >= NUM_REQ) s = s - NUM_REQ;
        return IDX_W'(s);
    endfunction

`ifdef XIF_ARB_LOCK_EN
    logic             r_locked;
    logic [IDX_W-1:0] r_lock_id;

    // A locked owner is the only eligible client; the pointer stays put until it releases.
    assign w_elig = r_locked ? (req_valid_i & (NUM_REQ'(1) << r_lock_id)) : req_valid_i;
    assign w_adv  = !req_lock_i[w_win];

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_locked  <= 1'b0;
            r_lock_id <= '0;
        end else if (w_grant) begin
            r_locked  <= req_lock_i[w_win];
            r_lock_id <= w_win;
        end
    end
`else
    logic w_unused_lock;
    assign w_unused_lock = ^req_lock_i;
    assign w_elig        = req_valid_i;
    assign w_adv         = 1'b1;
`endif

    always_comb begin
        w_found = 1'b0;
        w_win   = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (!w_found && w_elig[rr_idx(r_rr_ptr, i)]) begin
                w_found = 1'b1;
                w_win   = rr_idx(r_rr_ptr, i);
            end
        end
    end

    assign w_sel           = 32'(w_win);
    assign w_sel_req.addr  = req_addr_i[w_sel*ADDR_W +: ADDR_W];
    assign w_sel_req.we    = req_we_i[w_win];
    assign w_sel_req.be    = req_be_i[w_sel*BE_W +: BE_W];
    assign w_sel_req.wdata = req_wdata_i[w_sel*DATA_W +: DATA_W];

    // Reset gates the combinational handshakes so every output is 0 while rst_ni is low.
    assign w_grant = rst_ni && (r_state == ARB_IDLE) && w_found && (r_count < MAX_CNT);
    assign w_hs    = (r_state == ARB_ISSUE) && mem_ready_i;
    assign w_resp  = rst_ni && mem_result_valid_i && !w_fifo_empty;

    assign req_ready_o  = w_grant ? (NUM_REQ'(1) << w_win) : '0;
    assign resp_valid_o = w_resp ? (NUM_REQ'(1) << w_fifo_head) : '0;
    assign resp_rdata_o = w_resp ? mem_result_rdata_i : '0;
    assign mem_valid_o  = (r_state == ARB_ISSUE);
    assign mem_addr_o   = r_req.addr;
    assign mem_we_o     = r_req.we;
    assign mem_be_o     = r_req.be;
    assign mem_wdata_o  = r_req.wdata;
    assign mem_id_o     = r_tag;
    assign err_o        = r_err;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state  <= ARB_IDLE;
            r_req    <= '0;
            r_src    <= '0;
            r_count  <= '0;
            r_tag    <= '0;
            r_rr_ptr <= '0;
            r_err    <= 1'b0;
        end else begin
            unique case (r_state)
                ARB_IDLE: if (w_grant) begin
                    r_state <= ARB_ISSUE;
                    r_src   <= w_win;
                    r_req   <= w_sel_req;
                    if (w_adv) r_rr_ptr <= rr_idx(w_win, 1);
                end
                ARB_ISSUE: if (mem_ready_i) begin
                    r_state <= ARB_IDLE;
                    r_tag   <= r_tag + 1'b1;
                end
                default: r_state <= ARB_IDLE;
            endcase
            unique case ({w_grant, w_resp})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: ;
            endcase
            if (mem_result_valid_i && w_fifo_empty) r_err <= 1'b1;
        end
    end

    arb_route_fifo #(
        .DEPTH (MAX_OUTST),
        .WIDTH (IDX_W)
    ) u_route_fifo (
        .clk_i      (clk_i),
        .rst_ni     (rst_ni),
        .push_i     (w_hs),
        .push_dat_i (r_src),
        .pop_i      (w_resp),
        .pop_dat_o  (w_fifo_head),
        .full_o     (w_fifo_full_unused),
        .empty_o    (w_fifo_empty)
    );

endmodule

// File: tb/tb_xif_mem_arbiter.sv
// Random traffic bench for xif_mem_arbiter: a transaction-level model predicts every cycle's outputs
// into a queue that a separate negedge monitor pops and compares.
module tb_xif_mem_arbiter;

    localparam int NR  = 2;
    localparam int MO  = 2;
    localparam int IDW = 4;

    logic              clk_i = 1'b0;
    logic              rst_ni = 1'b0;
    logic [NR-1:0]     req_valid_i = '0;
    logic [NR-1:0]     req_ready_o;
    logic [NR*32-1:0]  req_addr_i = '0;
    logic [NR-1:0]     req_we_i = '0;
    logic [NR*4-1:0]   req_be_i = '0;
    logic [NR*32-1:0]  req_wdata_i = '0;
    logic [NR-1:0]     req_lock_i = '0;
    logic [NR-1:0]     resp_valid_o;
    logic [31:0]       resp_rdata_o;
    logic              mem_valid_o;
    logic              mem_ready_i = 1'b0;
    logic [31:0]       mem_addr_o;
    logic              mem_we_o;
    logic [3:0]        mem_be_o;
    logic [31:0]       mem_wdata_o;
    logic [IDW-1:0]    mem_id_o;
    logic              mem_result_valid_i = 1'b0;
    logic [31:0]       mem_result_rdata_i = '0;
    logic              err_o;

    always #5 clk_i = ~clk_i;

    xif_mem_arbiter #(.NUM_REQ(NR), .MAX_OUTST(MO), .ID_WIDTH(IDW)) dut (
        .clk_i(clk_i), .rst_ni(rst_ni),
        .req_valid_i(req_valid_i), .req_ready_o(req_ready_o), .req_addr_i(req_addr_i),
        .req_we_i(req_we_i), .req_be_i(req_be_i), .req_wdata_i(req_wdata_i), .req_lock_i(req_lock_i),
        .resp_valid_o(resp_valid_o), .resp_rdata_o(resp_rdata_o),
        .mem_valid_o(mem_valid_o), .mem_ready_i(mem_ready_i), .mem_addr_o(mem_addr_o),
        .mem_we_o(mem_we_o), .mem_be_o(mem_be_o), .mem_wdata_o(mem_wdata_o), .mem_id_o(mem_id_o),
        .mem_result_valid_i(mem_result_valid_i), .mem_result_rdata_i(mem_result_rdata_i),
        .err_o(err_o)
    );

    typedef struct packed {
        logic [NR-1:0] ready;
        logic          mvalid;
        logic [72:0]   mem;
        logic [NR-1:0] resp;
        logic [31:0]   rdata;
        logic          err;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   failures = 0;

    // Model state: pending client requests, transactions awaiting a response, arbitration history.
    logic [NR-1:0] pv = '0;
    logic [31:0]   pa[NR];
    logic          pw[NR];
    logic [3:0]    pb[NR];
    logic [31:0]   pd[NR];
    int            down[$];
    int            cnt = 0, last = NR - 1, tag = 0, cur_c = 0;
    bit            issuing = 0, errm = 0;
    logic [72:0]   cur_mem = '0;
`ifdef XIF_ARB_LOCK_EN
    bit            locked = 0;
    int            lk = 0;
`endif

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
        end
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk_i);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("req_ready", 128'(req_ready_o), 128'(e.ready));
                chk("mem_valid", 128'(mem_valid_o), 128'(e.mvalid));
                if (e.mvalid)
                    chk("mem_fields", 128'({mem_addr_o, mem_we_o, mem_be_o, mem_wdata_o, mem_id_o}), 128'(e.mem));
                chk("resp_valid", 128'(resp_valid_o), 128'(e.resp));
                if (e.resp != '0) chk("resp_rdata", 128'(resp_rdata_o), 128'(e.rdata));
                chk("err", 128'(err_o), 128'(e.err));
            end
        end
    end

    task automatic drive_clients();
        for (int k = 0; k < NR; k++) begin
            req_valid_i[k]          = pv[k];
            req_addr_i[32*k +: 32]  = pa[k];
            req_we_i[k]             = pw[k];
            req_be_i[4*k +: 4]      = pb[k];
            req_wdata_i[32*k +: 32] = pd[k];
        end
    endtask

    task automatic do_reset(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk_i); #1;
            rst_ni = 1'b0;
            drive_clients();
            mem_ready_i = 1'b0;
            mem_result_valid_i = 1'b0;
            down.delete();
            cnt = 0; last = NR - 1; tag = 0; issuing = 0; errm = 0;
`ifdef XIF_ARB_LOCK_EN
            locked = 0;
`endif
            exp_q.push_back('0);
        end
    endtask

    task automatic do_cycle(input bit gen, input int rpct, input bit late);
        exp_t          e;
        int            c0, w, c;
        bit            rv;
        logic [31:0]   rd;
        logic [NR-1:0] elig;
        @(posedge clk_i); #1;
        rst_ni = 1'b1;
        for (int k = 0; k < NR; k++) begin
            if (gen && !pv[k] && $urandom_range(1) == 1) begin
                pv[k] = 1'b1;
                pa[k] = $urandom;
                pw[k] = 1'($urandom_range(1));
                pb[k] = 4'($urandom);
                pd[k] = $urandom;
            end
        end
        drive_clients();
        req_lock_i  = NR'($urandom);
        mem_ready_i = 1'($urandom_range(1));
        rv = late || (down.size() > 0 && $urandom_range(99) < rpct);
        rd = $urandom;
        mem_result_valid_i = rv;
        mem_result_rdata_i = rd;

        e = '0;
        e.err = errm;
        c0 = cnt;
        e.mvalid = issuing;
        if (issuing) e.mem = cur_mem;
        if (rv) begin
            if (down.size() > 0) begin
                w = down.pop_front();
                e.resp  = NR'(1) << w;
                e.rdata = rd;
                cnt--;
            end else begin
                errm = 1;
            end
        end
        if (issuing) begin
            if (mem_ready_i) begin
                down.push_back(cur_c);
                tag = (tag + 1) % (1 << IDW);
                issuing = 0;
            end
        end else if (c0 < MO) begin
            elig = pv;
`ifdef XIF_ARB_LOCK_EN
            if (locked) elig = pv & (NR'(1) << lk);
`endif
            w = -1;
            for (int i = 0; i < NR; i++) begin
                c = (last + 1 + i) % NR;
                if (w < 0 && elig[c]) w = c;
            end
            if (w >= 0) begin
                e.ready = NR'(1) << w;
                cur_c   = w;
                cur_mem = {pa[w], pw[w], pb[w], pd[w], IDW'(tag)};
                issuing = 1;
                cnt++;
                pv[w] = 1'b0;
`ifdef XIF_ARB_LOCK_EN
                if (req_lock_i[w]) begin
                    locked = 1; lk = w;
                end else begin
                    locked = 0; last = w;
                end
`else
                last = w;
`endif
            end
        end
        exp_q.push_back(e);
    endtask

    initial begin : stim
        for (int k = 0; k < NR; k++) begin
            pa[k] = '0; pw[k] = 1'b0; pb[k] = '0; pd[k] = '0;
        end
        do_reset(3);
        for (int i = 0; i < 600; i++) do_cycle(1, 60, 0);
        // Rare responses keep the outstanding limit saturated.
        for (int i = 0; i < 400; i++) do_cycle(1, 5, 0);
        for (int i = 0; i < 50 && !issuing; i++) do_cycle(1, 50, 0);
        do_reset(2);
        do_cycle(1, 0, 1);
        for (int i = 0; i < 600; i++) do_cycle(1, 50, 0);
        for (int i = 0; i < 60; i++) do_cycle(0, 100, 0);
        do_cycle(0, 0, 1);
        do_cycle(0, 0, 0);
        do_cycle(0, 0, 0);
        @(negedge clk_i);
        @(negedge clk_i);
        #1;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_drain actual=%0d required=0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
